// File: rtl/audio_pkg.sv
// Shared constants for the sample buffer controller: FSM state encoding and
// parameter defaults.
package audio_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAY    = 2'd1;
    localparam logic [1:0] ST_STARVED = 2'd2;

    // 44.1 kHz sample rate from a 28.224 MHz master clock.
    localparam int SAMPLE_DIV_DEF = 640;
    localparam int RD_LAT_DEF     = 2;
    localparam int ADDR_W_DEF     = 11;
    localparam int DATA_W_DEF     = 16;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period phase divider: counts 0..SAMPLE_DIV-1 while enabled and emits
// the read-issue, capture and period-wrap strobes.
module sample_tick_gen
    import audio_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int RD_LAT     = RD_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic rd_stb_o,
    output logic cap_stb_o,
    output logic wrap_stb_o
);

    localparam int PH_W = $clog2(SAMPLE_DIV);

    logic [PH_W-1:0] phase_q, phase_d;
    logic            last_phase;

    assign last_phase = (phase_q == PH_W'(SAMPLE_DIV - 1));

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves phase_d
        // unassigned; otherwise synthesis infers a latch.
        phase_d = phase_q;
        if (clr_i) begin
            phase_d = '0;
        end else if (en_i) begin
            phase_d = last_phase ? '0 : phase_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, matching real hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign rd_stb_o   = en_i && (phase_q == '0);
    assign cap_stb_o  = en_i && (phase_q == PH_W'(RD_LAT));
    assign wrap_stb_o = en_i && last_phase;

endmodule

// File: rtl/sample_buf_ctrl.sv
// Double-buffered audio playback controller: streams one RAM sample per sample
// period, hands half-buffers back to the host and arbitrates host writes.
module sample_buf_ctrl
    import audio_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              half_ready,
    input  logic              half_sel,
    input  logic              host_wr_req,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              host_wr_gnt,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_vld,
    output logic              irq_half,
    output logic              cur_half,
    output logic              underrun,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic [1:0]        rdy_q, rdy_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              cur_half_q, cur_half_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              vld_q, vld_d;
    logic              irq_q, irq_d;
    logic              underrun_q, underrun_d;

    logic start_ok, rd_stb, cap_stb, wrap_stb, rd_issue, half_end, new_half;

    assign start_ok = (state_q == ST_IDLE) && start && rdy_q[0] && !stop;
    assign rd_issue = rd_stb && (state_q == ST_PLAY);
    assign half_end = &rd_addr_q[ADDR_W-2:0];
    assign new_half = ~cur_half_q;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .RD_LAT     (RD_LAT)
    ) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (state_q != ST_IDLE),
        .clr_i      (stop || start_ok),
        .rd_stb_o   (rd_stb),
        .cap_stb_o  (cap_stb),
        .wrap_stb_o (wrap_stb)
    );

    always_comb begin
        state_d    = state_q;
        rdy_d      = rdy_q;
        rd_addr_d  = rd_addr_q;
        cur_half_d = cur_half_q;
        sample_d   = sample_q;
        vld_d      = 1'b0;
        irq_d      = 1'b0;
        underrun_d = underrun_q;

        if (half_ready) begin
            rdy_d[half_sel] = 1'b1;
        end

        if (stop) begin
            state_d    = ST_IDLE;
            rd_addr_d  = '0;
            cur_half_d = 1'b0;
        end else begin
            if (cap_stb) begin
                vld_d    = 1'b1;
                sample_d = (state_q == ST_PLAY) ? ram_rdata : '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_d    = ST_PLAY;
                        rd_addr_d  = '0;
                        cur_half_d = 1'b0;
                        underrun_d = 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (wrap_stb) begin
                        rd_addr_d = rd_addr_q + 1'b1;
                        // The release of the finished half overrides a same-cycle
                        // half_ready for it, since it is assigned afterwards.
                        if (half_end) begin
                            rdy_d[cur_half_q] = 1'b0;
                            irq_d             = 1'b1;
                            cur_half_d        = new_half;
                            if (!rdy_q[new_half]) begin
                                state_d    = ST_STARVED;
                                underrun_d = 1'b1;
                            end
                        end
                    end
                end
                ST_STARVED: begin
                    if (wrap_stb && rdy_q[cur_half_q]) begin
                        state_d = ST_PLAY;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rdy_q      <= '0;
            rd_addr_q  <= '0;
            cur_half_q <= 1'b0;
            sample_q   <= '0;
            vld_q      <= 1'b0;
            irq_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= rdy_d;
            rd_addr_q  <= rd_addr_d;
            cur_half_q <= cur_half_d;
            sample_q   <= sample_d;
            vld_q      <= vld_d;
            irq_q      <= irq_d;
            underrun_q <= underrun_d;
        end
    end

    // Playback read owns the RAM port at phase 0; the host gets every other cycle.
    assign host_wr_gnt = host_wr_req && !rd_issue;
    assign ram_en      = rd_issue || host_wr_req;
    assign ram_we      = host_wr_gnt;
    assign ram_addr    = rd_issue ? rd_addr_q : host_wr_addr;
    assign ram_wdata   = host_wr_data;

    assign sample_out = sample_q;
    assign sample_vld = vld_q;
    assign irq_half   = irq_q;
    assign cur_half   = cur_half_q;
    assign underrun   = underrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sample_buf_ctrl.sv
// Self-checking bench for sample_buf_ctrl: directed playback scenarios plus
// random traffic, compared every cycle against a behavioural reference model.
module tb_sample_buf_ctrl;

    localparam int DIV   = 8;
    localparam int LAT   = 2;
    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int HALF  = DEPTH / 2;

    localparam int M_IDLE    = 0;
    localparam int M_PLAY    = 1;
    localparam int M_STARVED = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0, stop = 1'b0, half_ready = 1'b0, half_sel = 1'b0;
    logic          host_wr_req = 1'b0;
    logic [AW-1:0] host_wr_addr = '0;
    logic [DW-1:0] host_wr_data = '0;
    logic          host_wr_gnt, ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata, sample_out;
    logic          sample_vld, irq_half, cur_half, underrun, busy;

    always #5 clk = ~clk;

    sample_buf_ctrl #(
        .SAMPLE_DIV (DIV),
        .RD_LAT     (LAT),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .half_ready   (half_ready),
        .half_sel     (half_sel),
        .host_wr_req  (host_wr_req),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .host_wr_gnt  (host_wr_gnt),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .sample_out   (sample_out),
        .sample_vld   (sample_vld),
        .irq_half     (irq_half),
        .cur_half     (cur_half),
        .underrun     (underrun),
        .busy         (busy)
    );

    // Single-port RAM with 1-cycle read latency, preloaded from init_val.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] init_val [DEPTH];
    logic          mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val[i];
        end else begin
            if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
            if (ram_en && ram_we)  mem[ram_addr] <= ram_wdata;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: playback state in plain integers, plus a shadow of the RAM.
    int            m_state, m_phase, m_addr, m_half;
    bit            m_under, m_vld, m_irq;
    bit            m_rdy [2];
    logic [DW-1:0] m_sample, m_rdq;
    logic [DW-1:0] shadow [DEPTH];

    int vld_cnt, irq_cnt, rd_cnt, first_rd_addr;

    task automatic model_reset();
        m_state  = M_IDLE;
        m_phase  = 0;
        m_addr   = 0;
        m_half   = 0;
        m_under  = 0;
        m_vld    = 0;
        m_irq    = 0;
        m_rdy[0] = 0;
        m_rdy[1] = 0;
        m_sample = '0;
    endtask

    task automatic model_next(input bit rd, input bit gnt);
        bit rdy_old [2];
        rdy_old[0] = m_rdy[0];
        rdy_old[1] = m_rdy[1];
        if (rd)  m_rdq = shadow[m_addr];
        if (gnt) shadow[host_wr_addr] = host_wr_data;
        if (half_ready) m_rdy[half_sel] = 1;
        m_vld = 0;
        m_irq = 0;
        if (stop) begin
            m_state = M_IDLE;
            m_phase = 0;
            m_addr  = 0;
            m_half  = 0;
        end else if (m_state == M_IDLE) begin
            if (start && rdy_old[0]) begin
                m_state = M_PLAY;
                m_phase = 0;
                m_addr  = 0;
                m_half  = 0;
                m_under = 0;
            end
        end else begin
            if (m_phase == LAT) begin
                m_vld    = 1;
                m_sample = (m_state == M_PLAY) ? m_rdq : '0;
            end
            if (m_phase == DIV - 1) begin
                m_phase = 0;
                if (m_state == M_PLAY) begin
                    if (m_addr % HALF == HALF - 1) begin
                        m_rdy[m_half] = 0;
                        m_irq         = 1;
                        m_half        = 1 - m_half;
                        if (!rdy_old[m_half]) begin
                            m_state = M_STARVED;
                            m_under = 1;
                        end
                    end
                    m_addr = (m_addr + 1) % DEPTH;
                end else if (rdy_old[m_half]) begin
                    m_state = M_PLAY;
                end
            end else begin
                m_phase++;
            end
        end
    endtask

    // One clock: compare at the falling edge, advance model, release pulses.
    task automatic cycle();
        bit rd, gnt;
        @(negedge clk);
        rd  = (m_state == M_PLAY) && (m_phase == 0);
        gnt = host_wr_req && !rd;
        check("busy", 32'(busy), 32'(m_state != M_IDLE));
        check("ram_en", 32'(ram_en), 32'(rd || host_wr_req));
        check("ram_we", 32'(ram_we), 32'(gnt));
        check("host_wr_gnt", 32'(host_wr_gnt), 32'(gnt));
        if (rd) begin
            check("rd_addr", 32'(ram_addr), 32'(m_addr));
        end else if (gnt) begin
            check("wr_addr", 32'(ram_addr), 32'(host_wr_addr));
            check("wr_data", 32'(ram_wdata), 32'(host_wr_data));
        end
        check("sample_out", 32'(sample_out), 32'(m_sample));
        check("sample_vld", 32'(sample_vld), 32'(m_vld));
        check("irq_half", 32'(irq_half), 32'(m_irq));
        check("cur_half", 32'(cur_half), 32'(m_half));
        check("underrun", 32'(underrun), 32'(m_under));
        if (sample_vld) vld_cnt++;
        if (irq_half) irq_cnt++;
        if (ram_en && !ram_we) begin
            if (rd_cnt == 0) first_rd_addr = int'(ram_addr);
            rd_cnt++;
        end
        model_next(rd, gnt);
        @(posedge clk);
        #1;
        start      = 1'b0;
        stop       = 1'b0;
        half_ready = 1'b0;
        if (gnt) host_wr_req = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        host_wr_req = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sample_out", 32'(sample_out), 32'd0);
        check("rst_sample_vld", 32'(sample_vld), 32'd0);
        check("rst_irq", 32'(irq_half), 32'd0);
        check("rst_cur_half", 32'(cur_half), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_half(input logic sel);
        for (int i = 0; i < DIV && m_phase == DIV - 1; i++) cycle();
        half_ready = 1'b1;
        half_sel   = sel;
        cycle();
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 4 * DIV && !(m_state == M_PLAY && m_phase == ph); i++) cycle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            init_val[i] = DW'($urandom);
            shadow[i]   = init_val[i];
        end
        #2;
        do_reset();
        mem_init_done = 1'b1;

        // Start with no half ready is ignored; then play half 0.
        start = 1'b1;
        cycle();
        check("start_ignored", 32'(busy), 32'd0);
        pulse_half(1'b0);
        start = 1'b1;
        cycle();
        vld_cnt = 0;
        rd_cnt  = 0;
        run(3 * DIV);
        check("vld_per_period", 32'(vld_cnt), 32'd3);
        check("reads_per_period", 32'(rd_cnt), 32'd3);

        // Both halves ready: crossing into half 1 without underrun.
        pulse_half(1'b1);
        irq_cnt = 0;
        run(13 * DIV + 2);
        check("irq_first_cross", 32'(irq_cnt), 32'd1);
        check("half_after_cross", 32'(cur_half), 32'd1);
        check("no_underrun", 32'(underrun), 32'd0);

        // Half 0 released and not refilled: starve at the wrap back to 0.
        irq_cnt = 0;
        run(16 * DIV);
        check("irq_second_cross", 32'(irq_cnt), 32'd1);
        check("underrun_set", 32'(underrun), 32'd1);
        vld_cnt = 0;
        run(2 * DIV);
        check("starved_vld", 32'(vld_cnt), 32'd2);
        check("starved_sample", 32'(sample_out), 32'd0);
        check("starved_busy", 32'(busy), 32'd1);
        pulse_half(1'b0);
        rd_cnt = 0;
        run(2 * DIV);
        check("resume_rd_addr", 32'(first_rd_addr), 32'd0);
        check("underrun_sticky", 32'(underrun), 32'd1);

        // Host write held across a playback read.
        wait_phase(0);
        host_wr_req  = 1'b1;
        host_wr_addr = AW'(3);
        host_wr_data = 16'hbeef;
        check("gnt_blocked", 32'(host_wr_gnt), 32'd0);
        cycle();
        check("gnt_next", 32'(host_wr_gnt), 32'd1);
        cycle();
        check("req_dropped", 32'(host_wr_req), 32'd0);

        // Stop mid-period.
        wait_phase(5);
        stop = 1'b1;
        cycle();
        check("stop_idle", 32'(busy), 32'd0);
        vld_cnt = 0;
        run(2 * DIV);
        check("stop_no_vld", 32'(vld_cnt), 32'd0);
        start = 1'b1;
        cycle();
        check("rdy_kept_restart", 32'(busy), 32'd1);
        run(DIV + 3);
        do_reset();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 150) == 0) start = 1'b1;
            if ($urandom_range(0, 400) == 0) stop = 1'b1;
            if (m_phase != DIV - 1 && $urandom_range(0, 40) == 0) begin
                half_ready = 1'b1;
                half_sel   = 1'($urandom_range(0, 1));
            end
            if (!host_wr_req && $urandom_range(0, 5) == 0) begin
                host_wr_req  = 1'b1;
                host_wr_addr = AW'($urandom);
                host_wr_data = DW'($urandom);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
